// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute-stage controller and the
// iterative multiply/divide sequencer.
interface muldiv_seq_if;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        busy;
  logic        done;
  logic [31:0] MulDivResult;

  modport master (
    output start, kill, funct3, ReadData1, ReadData2,
    input  busy, done, MulDivResult
  );

  modport slave (
    input  start, kill, funct3, ReadData1, ReadData2,
    output busy, done, MulDivResult
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide sharing one 33-bit adder, with sign fix-up in a final FIX cycle.
module muldiv_seq #(
  parameter bit EARLY_OUT = 1'b1
) (
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e      r_state, w_state_d;
  logic [4:0]  r_cnt, w_cnt_d;
  logic [2:0]  r_f3, w_f3_d;
  logic [31:0] r_hi, w_hi_d;
  logic [31:0] r_lo, w_lo_d;
  logic [31:0] r_b, w_b_d;
  logic [31:0] r_result, w_result_d;
  logic        r_neg, w_neg_d;

  // Accept-time decode of the incoming request
  logic        w_is_div, w_is_rem, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;
  logic        w_div0, w_ovf, w_special, w_res_neg;
  logic [31:0] w_special_res;

  assign w_is_div   = bus.funct3[2];
  assign w_is_rem   = bus.funct3[2] & bus.funct3[1];
  assign w_a_signed = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
  assign w_b_signed = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
  assign w_a_neg    = w_a_signed & bus.ReadData1[31];
  assign w_b_neg    = w_b_signed & bus.ReadData2[31];
  assign w_a_mag    = w_a_neg ? (~bus.ReadData1 + 32'd1) : bus.ReadData1;
  assign w_b_mag    = w_b_neg ? (~bus.ReadData2 + 32'd1) : bus.ReadData2;

  assign w_div0     = (bus.ReadData2 == 32'd0);
  assign w_ovf      = w_is_div & ~bus.funct3[0] & (bus.ReadData1 == 32'h8000_0000) &
                      (bus.ReadData2 == 32'hFFFF_FFFF);
  assign w_special  = w_is_div & (w_div0 | w_ovf);
  assign w_special_res = w_div0 ? (w_is_rem ? bus.ReadData1 : 32'hFFFF_FFFF)
                                : (w_is_rem ? 32'd0 : 32'h8000_0000);

  // Divide-by-zero quotient must stay all-ones, so its sign is forced positive
  assign w_res_neg  = w_is_rem ? w_a_neg :
                      w_is_div ? ((w_a_neg ^ w_b_neg) & ~w_div0) : (w_a_neg ^ w_b_neg);

  // Shared adder: add multiplicand, or subtract divisor from the shifted remainder
  logic [32:0] w_shift, w_add_a, w_add_b, w_sum;

  assign w_shift = {r_hi, r_lo[31]};
  assign w_add_a = r_f3[2] ? w_shift : {1'b0, r_hi};
  assign w_add_b = r_f3[2] ? ~{1'b0, r_b} : (r_lo[0] ? {1'b0, r_b} : 33'd0);
  assign w_sum   = w_add_a + w_add_b + {32'd0, r_f3[2]};

  // Sign fix-up; the high-word negate borrows the carry out of the low word
  logic [31:0] w_lo_neg, w_hi_neg, w_lo_sel, w_hi_sel, w_fix;

  assign w_lo_neg = ~r_lo + 32'd1;
  assign w_hi_neg = ~r_hi + {31'd0, r_f3[2] | (r_lo == 32'd0)};
  assign w_lo_sel = r_neg ? w_lo_neg : r_lo;
  assign w_hi_sel = r_neg ? w_hi_neg : r_hi;
  assign w_fix    = r_f3[2] ? (r_f3[1] ? w_hi_sel : w_lo_sel)
                            : ((r_f3[1:0] == 2'b00) ? w_lo_sel : w_hi_sel);

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_f3_d     = r_f3;
    w_hi_d     = r_hi;
    w_lo_d     = r_lo;
    w_b_d      = r_b;
    w_neg_d    = r_neg;
    w_result_d = r_result;

    case (r_state)
      StIdle: begin
        if (bus.start && !bus.kill) begin
          w_f3_d  = bus.funct3;
          w_cnt_d = 5'd0;
          w_neg_d = w_res_neg;
          w_hi_d  = 32'd0;
          w_lo_d  = w_is_div ? w_a_mag : w_b_mag;
          w_b_d   = w_is_div ? w_b_mag : w_a_mag;
          if (EARLY_OUT && w_special) begin
            w_result_d = w_special_res;
            w_state_d  = StDone;
          end else begin
            w_state_d  = StCalc;
          end
        end
      end
      StCalc: begin
        if (bus.kill) begin
          w_state_d = StIdle;
        end else begin
          if (r_f3[2]) begin
            w_hi_d = w_sum[32] ? w_shift[31:0] : w_sum[31:0];
            w_lo_d = {r_lo[30:0], ~w_sum[32]};
          end else begin
            w_hi_d = w_sum[32:1];
            w_lo_d = {w_sum[0], r_lo[31:1]};
          end
          w_cnt_d = r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            w_state_d = StFix;
          end
        end
      end
      StFix: begin
        if (bus.kill) begin
          w_state_d = StIdle;
        end else begin
          w_result_d = w_fix;
          w_state_d  = StDone;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= 5'd0;
      r_f3     <= 3'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_b      <= 32'd0;
      r_neg    <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_f3     <= w_f3_d;
      r_hi     <= w_hi_d;
      r_lo     <= w_lo_d;
      r_b      <= w_b_d;
      r_neg    <= w_neg_d;
      r_result <= w_result_d;
    end
  end

  assign bus.busy         = (r_state != StIdle);
  assign bus.done         = (r_state == StDone) & ~bus.kill;
  assign bus.MulDivResult = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench: an early-out and a full-loop sequencer run the same
// vectors side by side; results, done timing and busy length are checked.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int          n_tests;
  int          n_fail;
  logic [31:0] last_res;

  muldiv_seq_if if_eo ();
  muldiv_seq_if if_full ();

  assign if_eo.start       = start;
  assign if_eo.kill        = kill;
  assign if_eo.funct3      = funct3;
  assign if_eo.ReadData1   = rd1;
  assign if_eo.ReadData2   = rd2;
  assign if_full.start     = start;
  assign if_full.kill      = kill;
  assign if_full.funct3    = funct3;
  assign if_full.ReadData1 = rd1;
  assign if_full.ReadData2 = rd2;

  muldiv_seq #(.EARLY_OUT(1'b1)) u_dut_eo (
    .clk (clk),
    .rst (rst),
    .bus (if_eo)
  );

  muldiv_seq #(.EARLY_OUT(1'b0)) u_dut_full (
    .clk (clk),
    .rst (rst),
    .bus (if_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUTs idle; the accept edge is the next posedge.
  // eo_edge is the number of edges after accept at which the early-out DUT's
  // done cycle begins (33 on the normal path, 0 for an early-out case).
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int eo_edge, input bit hold,
                        input string tag);
    int at_eo, at_full, nd_eo, nd_full, nb_eo, nb_full;
    at_eo = -1; at_full = -1; nd_eo = 0; nd_full = 0; nb_eo = 0; nb_full = 0;
    funct3 = f3; rd1 = a; rd2 = b; start = 1'b1; kill = 1'b0;
    @(posedge clk);
    #1;
    start  = hold;
    funct3 = ~f3;
    rd1    = ~a;
    rd2    = ~b;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (if_eo.done) begin
        nd_eo++;
        if (at_eo < 0) at_eo = k;
      end
      if (if_full.done) begin
        nd_full++;
        if (at_full < 0) at_full = k;
      end
      if (if_eo.busy) nb_eo++;
      if (if_full.busy) nb_full++;
      if (hold) begin
        rd1    = $urandom;
        rd2    = $urandom;
        funct3 = 3'($urandom_range(0, 7));
      end
    end
    start = 1'b0;
    check_eq({tag, " eo result"}, if_eo.MulDivResult, exp);
    check_eq({tag, " full result"}, if_full.MulDivResult, exp);
    check_eq({tag, " eo done edge"}, at_eo, eo_edge);
    check_eq({tag, " full done edge"}, at_full, 33);
    check_eq({tag, " eo done pulses"}, nd_eo, 1);
    check_eq({tag, " full done pulses"}, nd_full, 1);
    check_eq({tag, " eo busy cycles"}, nb_eo, (eo_edge == 0) ? 1 : 34);
    check_eq({tag, " full busy cycles"}, nb_full, 34);
    last_res = exp;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got stuck, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int nd;
    n_tests = 0; n_fail = 0; last_res = 32'd0;
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; rd1 = 32'd0; rd2 = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("reset eo busy", {31'd0, if_eo.busy}, 32'd0);
    check_eq("reset eo done", {31'd0, if_eo.done}, 32'd0);
    check_eq("reset eo result", if_eo.MulDivResult, 32'd0);
    check_eq("reset full result", if_full.MulDivResult, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0, "MUL 7*-3");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0, "MULH");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0, "MULHU");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0, "MULHSU");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b0, "DIV -7/2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0, "REM -7/2");
    run_op(3'b101, 32'd100,       32'd7,         32'd14,        33, 1'b1, "DIVU hold");
    run_op(3'b111, 32'd100,       32'd7,         32'd2,         33, 1'b0, "REMU 100/7");
    run_op(3'b000, 32'd0,         32'h0001_2345, 32'd0,         33, 1'b0, "MUL zero");
    run_op(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 0,  1'b0, "DIVU by 0");
    run_op(3'b110, 32'd5,         32'd0,         32'd5,         0,  1'b0, "REM by 0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0,  1'b0, "DIV ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0,  1'b0, "REM ovf");
    run_op(3'b101, 32'd100,       32'd7,         32'd14,        33, 1'b0, "DIVU 100/7");

    // kill together with start in IDLE: nothing is accepted
    start = 1'b1; kill = 1'b1; funct3 = 3'b000; rd1 = 32'd9; rd2 = 32'd9;
    @(negedge clk);
    check_eq("kill+start eo busy", {31'd0, if_eo.busy}, 32'd0);
    check_eq("kill+start full busy", {31'd0, if_full.busy}, 32'd0);
    start = 1'b0; kill = 1'b0;

    // kill applied on the edge of CALC iteration 10
    funct3 = 3'b000; rd1 = 32'd11; rd2 = 32'd13; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check_eq("kill eo busy", {31'd0, if_eo.busy}, 32'd0);
    check_eq("kill full busy", {31'd0, if_full.busy}, 32'd0);
    check_eq("kill eo result", if_eo.MulDivResult, last_res);
    check_eq("kill full result", if_full.MulDivResult, last_res);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (if_eo.done || if_full.done) nd++;
    end
    check_eq("kill no done", nd, 0);

    // asynchronous reset in the middle of CALC
    funct3 = 3'b000; rd1 = 32'd5; rd2 = 32'd6; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midreset eo busy", {31'd0, if_eo.busy}, 32'd0);
    check_eq("midreset full busy", {31'd0, if_full.busy}, 32'd0);
    check_eq("midreset eo done", {31'd0, if_eo.done}, 32'd0);
    check_eq("midreset eo result", if_eo.MulDivResult, 32'd0);
    check_eq("midreset full result", if_full.MulDivResult, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(3'b000, 32'd3, 32'd4, 32'd12, 33, 1'b0, "MUL 3*4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with a radix-2 shift-add / restoring-divide loop over one shared 33-bit adder.
- Sits beside the ALU in the execute stage. The controller stalls the PC while busy and selects MulDivResult for writeback when done pulses.

Parameters:
- EARLY_OUT, 1, 1 = divide-by-zero and signed-overflow cases complete in 1 cycle, skipping CALC; 0 = they run the full loop with the same final results.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only on a rising edge where state is IDLE
- kill  input  1  synchronous abort of the operation in flight
- funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- ReadData1  input  32  rs1, multiplicand/dividend; sampled only at accept
- ReadData2  input  32  rs2, multiplier/divisor; sampled only at accept
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse; MulDivResult valid
- MulDivResult  output  32  result; held until the next accepted start

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, busy=0, done=0, MulDivResult=0, all internal operand registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and kill=0 at edge E0: latch funct3, the operand magnitudes and the result sign; counter=0; next state CALC.
  - If EARLY_OUT=1 and a special case applies, next state is DONE directly, with MulDivResult loaded at E0.
- CALC: one iteration per edge, counter increments each edge. After the 32nd iteration (edge E32) next state is FIX.
- FIX (edge E33): apply sign correction (two's-complement negate when the result sign is 1), select the low/high product word or quotient/remainder, load MulDivResult, next state DONE.
- DONE: done=1 for exactly this cycle; next edge returns to IDLE.
- Latency: done high in the cycle after E33, i.e. 33 edges after accept. Early-out: done high in the cycle after E0.
- Throughput: start is ignored while busy=1, including during DONE. A new start is first accepted on the edge following DONE.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - Operands are converted to magnitudes at accept.
- Result sign:
  - Product: XOR of the operand signs.
  - Quotient: XOR of the operand signs.
  - Remainder: sign of the dividend.
- Product is 64 bits: MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide by zero:
  - DIV/DIVU: quotient = 0xFFFFFFFF.
  - REM/REMU: remainder = rs1.
- Signed overflow (DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF):
  - DIV: quotient = 0x80000000.
  - REM: remainder = 0.
- Special-case results are identical for EARLY_OUT=0 and EARLY_OUT=1; only latency differs.
- kill=1 in CALC, FIX or DONE: next state IDLE. done is not asserted for that operation (a pending done is suppressed) and MulDivResult keeps its prior value.
- kill=1 together with start=1 in IDLE: kill wins and nothing is accepted.
- Operand inputs may change freely after accept without affecting the result.
- Zero operands (e.g. 0*x, 0/x) take the normal path and full latency.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> MulDivResult=0xFFFFFFEB; done exactly 33 cycles after accept; busy high for 34 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, run with EARLY_OUT=1 and repeated with EARLY_OUT=0:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
  - Done after 1 cycle (EARLY_OUT=1) vs 33 cycles (EARLY_OUT=0).
- Assert start every cycle during a running op -> ignored; operands changed mid-op -> result unaffected; back-to-back ops accepted on the edge after DONE.
- kill at CALC iteration 10 -> busy=0 the next cycle, no done, MulDivResult unchanged. rst pulsed mid-CALC -> immediate IDLE with all outputs 0, then a fresh MUL 3x4 -> 12.
